// File: rtl/pwm_duty_ctrl.sv
// rtl/pwm_duty_ctrl.sv - PWM duty controller with button/load target and wrap-aligned duty ramp
// Duty only moves on the counter wrap, so every period compares against one stable duty value.
module pwm_duty_ctrl #(
  parameter int WIDTH        = 4,
  parameter int RAMP_PERIODS = 1
) (
  input  logic             CLoK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] CNTR,
  input  logic             INC,
  input  logic             DEC,
  input  logic             LD_VLD,
  input  logic [WIDTH:0]   LD_DUTY,
  output logic             LD_RDY,
  output logic [WIDTH:0]   DUTY,
  output logic [WIDTH:0]   TARGET,
  output logic             BUSY,
  output logic             PWM_OUT
);

  localparam logic [WIDTH:0]   DUTY_MAX  = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]   DUTY_ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNTR_LAST = '1;
  localparam logic [3:0]       STEP_LAST = 4'(RAMP_PERIODS - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t         state;
  state_t         state_next;
  logic [3:0]     step;
  logic [3:0]     step_next;
  logic [WIDTH:0] duty_next;
  logic [WIDTH:0] target_next;
  logic           wrap;

  assign wrap = (CNTR == CNTR_LAST);

  always_comb begin
    target_next = TARGET;
    if (LD_VLD && LD_RDY) begin
      target_next = (LD_DUTY > DUTY_MAX) ? DUTY_MAX : LD_DUTY;
    end else if (INC && !DEC) begin
      if (TARGET != DUTY_MAX) target_next = TARGET + DUTY_ONE;
    end else if (DEC && !INC) begin
      if (TARGET != '0) target_next = TARGET - DUTY_ONE;
    end
  end

  always_comb begin
    duty_next = DUTY;
    step_next = '0;
    if (state == RAMP && TARGET != DUTY) begin
      step_next = step;
      if (wrap) begin
        if (step == STEP_LAST) begin
          step_next = '0;
          duty_next = (TARGET > DUTY) ? DUTY + DUTY_ONE : DUTY - DUTY_ONE;
        end else begin
          step_next = step + 4'd1;
        end
      end
    end
    // Deciding on the post-update values lets a retarget onto DUTY drop straight back to IDLE.
    state_next = (target_next != duty_next) ? RAMP : IDLE;
    if (state_next == IDLE) step_next = '0;
  end

  always_ff @(posedge CLoK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      step    <= '0;
      DUTY    <= '0;
      TARGET  <= '0;
      LD_RDY  <= 1'b0;
      BUSY    <= 1'b0;
      PWM_OUT <= 1'b0;
    end else begin
      state   <= state_next;
      step    <= step_next;
      DUTY    <= duty_next;
      TARGET  <= target_next;
      LD_RDY  <= (state_next == IDLE);
      BUSY    <= (state_next == RAMP);
      PWM_OUT <= ({1'b0, CNTR} < DUTY);
    end
  end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb/tb_pwm_duty_ctrl.sv - scoreboard bench for pwm_duty_ctrl at RAMP_PERIODS 1 and 3
module tb_pwm_duty_ctrl;

  typedef struct packed {
    logic       rdy;
    logic [4:0] duty;
    logic [4:0] target;
    logic       busy;
    logic       pwm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cntr;
  logic       inc, dec, ld_vld;
  logic [4:0] ld_duty;
  logic       rdy1, busy1, pwm1, rdy3, busy3, pwm3;
  logic [4:0] duty1, target1, duty3, target3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t       q1[$];
  exp_t       q3[$];
  logic [4:0] m_duty[2];
  logic [4:0] m_target[2];
  logic       m_ramp[2];
  logic       m_rdy[2];
  int         m_cnt[2];

  pwm_duty_ctrl #(.WIDTH(4), .RAMP_PERIODS(1)) dut1 (
    .CLoK(clk), .RST_N(rst_n), .CNTR(cntr), .INC(inc), .DEC(dec),
    .LD_VLD(ld_vld), .LD_DUTY(ld_duty), .LD_RDY(rdy1), .DUTY(duty1),
    .TARGET(target1), .BUSY(busy1), .PWM_OUT(pwm1)
  );

  pwm_duty_ctrl #(.WIDTH(4), .RAMP_PERIODS(3)) dut3 (
    .CLoK(clk), .RST_N(rst_n), .CNTR(cntr), .INC(inc), .DEC(dec),
    .LD_VLD(ld_vld), .LD_DUTY(ld_duty), .LD_RDY(rdy3), .DUTY(duty3),
    .TARGET(target3), .BUSY(busy3), .PWM_OUT(pwm3)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_duty[i] = '0; m_target[i] = '0; m_ramp[i] = 1'b0; m_rdy[i] = 1'b0; m_cnt[i] = 0;
    end
    q1.delete();
    q3.delete();
  endtask

  task automatic model_step(input int i, input int rp, output exp_t e);
    logic [4:0] t, d;
    logic       p;
    p = ({1'b0, cntr} < m_duty[i]);
    t = m_target[i];
    d = m_duty[i];
    if (ld_vld && m_rdy[i])      t = (ld_duty > 5'd16) ? 5'd16 : ld_duty;
    else if (inc && !dec)        t = (t == 5'd16) ? t : t + 5'd1;
    else if (dec && !inc)        t = (t == 5'd0) ? t : t - 5'd1;
    if (m_ramp[i] && cntr == 4'd15 && m_target[i] != m_duty[i]) begin
      m_cnt[i]++;
      if (m_cnt[i] == rp) begin
        m_cnt[i] = 0;
        d = (m_target[i] > m_duty[i]) ? d + 5'd1 : d - 5'd1;
      end
    end
    m_ramp[i] = (t != d);
    if (!m_ramp[i]) m_cnt[i] = 0;
    m_rdy[i]    = !m_ramp[i];
    m_duty[i]   = d;
    m_target[i] = t;
    e.rdy = m_rdy[i]; e.duty = d; e.target = t; e.busy = m_ramp[i]; e.pwm = p;
  endtask

  initial begin
    cntr = '0;
    forever begin
      @(posedge clk);
      #1;
      cntr = cntr + 4'd1;
    end
  end

  initial begin : model_proc
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) begin
        model_step(0, 1, e);
        q1.push_back(e);
        model_step(1, 3, e);
        q3.push_back(e);
      end
    end
  end

  initial begin : monitor_proc
    exp_t       e;
    logic [4:0] prev1, prev3;
    logic [3:0] pc;
    prev1 = '0;
    prev3 = '0;
    forever begin
      @(negedge clk);
      pc = cntr - 4'd1;
      if (rst_n) begin
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check_eq("d1_rdy", rdy1, e.rdy);
          check_eq("d1_duty", duty1, e.duty);
          check_eq("d1_target", target1, e.target);
          check_eq("d1_busy", busy1, e.busy);
          check_eq("d1_pwm", pwm1, e.pwm);
        end
        if (q3.size() > 0) begin
          e = q3.pop_front();
          check_eq("d3_rdy", rdy3, e.rdy);
          check_eq("d3_duty", duty3, e.duty);
          check_eq("d3_target", target3, e.target);
          check_eq("d3_busy", busy3, e.busy);
          check_eq("d3_pwm", pwm3, e.pwm);
        end
        if (duty1 != prev1) check_eq("d1_step_at_wrap", pc, 15);
        if (duty3 != prev3) check_eq("d3_step_at_wrap", pc, 15);
      end
      prev1 = duty1;
      prev3 = duty3;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_duty", duty1, 0);
    check_eq("rst_target", target1, 0);
    check_eq("rst_busy", busy1, 0);
    check_eq("rst_rdy", rdy1, 0);
    check_eq("rst_pwm", pwm1, 0);
    check_eq("rst_duty3", duty3, 0);
    check_eq("rst_target3", target3, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check_eq("rdy_before_first_edge", rdy1, 0);
    @(negedge clk);
    check_eq("rdy_after_first_edge", rdy1, 1);
    tick();
  endtask

  task automatic do_load(input logic [4:0] d);
    logic acc;
    acc = 1'b0;
    ld_vld = 1'b1;
    ld_duty = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = rdy1;
      tick();
      if (acc) break;
    end
    ld_vld = 1'b0;
    check_eq("load_accepted", acc, 1);
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (!busy1 && duty1 == target1) break;
      tick();
    end
    @(negedge clk);
    check_eq("idle_busy", busy1, 0);
    check_eq("idle_duty_eq_target", duty1, target1);
    tick();
  endtask

  task automatic pwm_window(input int exp_high);
    int         n;
    logic [3:0] pc;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pc = cntr - 4'd1;
      if (pwm1) n++;
      check_eq("pwm_align", pwm1, ({1'b0, pc} < duty1));
      tick();
    end
    check_eq("pwm_high_count", n, exp_high);
  endtask

  initial begin
    int t1, t2;
    logic [4:0] prev;
    rst_n = 1'b0;
    inc = 1'b0; dec = 1'b0; ld_vld = 1'b0; ld_duty = '0;
    model_reset();
    tick();
    apply_reset();

    pwm_window(0);
    @(negedge clk);
    check_eq("idle_busy_after_reset", busy1, 0);
    tick();

    do_load(5'd4);
    @(negedge clk);
    check_eq("load4_target", target1, 4);
    check_eq("load4_busy", busy1, 1);
    check_eq("load4_rdy", rdy1, 0);
    tick();
    wait_idle(200);
    check_eq("load4_duty", duty1, 4);
    pwm_window(4);

    do_load(5'd31);
    @(negedge clk);
    check_eq("clamp_target", target1, 16);
    tick();
    wait_idle(400);
    pwm_window(16);
    dec = 1'b1;
    repeat (17) tick();
    dec = 1'b0;
    @(negedge clk);
    check_eq("dec_saturate_target", target1, 0);
    tick();
    wait_idle(400);
    check_eq("ramp_down_duty", duty1, 0);
    pwm_window(0);

    apply_reset();
    do_load(5'd2);
    t1 = -1;
    t2 = -1;
    prev = duty3;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (duty3 != prev) begin
        if (duty3 == 5'd1) t1 = cyc;
        if (duty3 == 5'd2) t2 = cyc;
        prev = duty3;
      end
      tick();
      if (t2 >= 0) break;
    end
    check_eq("rp3_final_duty", duty3, 2);
    check_eq("rp3_step_gap", t2 - t1, 48);

    apply_reset();
    do_load(5'd6);
    for (int i = 0; i < 100; i++) begin
      if (duty1 == 5'd2) break;
      tick();
    end
    dec = 1'b1;
    repeat (4) tick();
    dec = 1'b0;
    @(negedge clk);
    check_eq("retarget_target", target1, 2);
    check_eq("retarget_busy", busy1, 0);
    check_eq("retarget_duty", duty1, 2);
    tick();
    repeat (40) tick();
    @(negedge clk);
    check_eq("retarget_hold_duty", duty1, 2);
    tick();
    inc = 1'b1; dec = 1'b1;
    tick();
    inc = 1'b0; dec = 1'b0;
    @(negedge clk);
    check_eq("incdec_target", target1, 2);
    tick();
    ld_vld = 1'b1; ld_duty = 5'd9; inc = 1'b1;
    tick();
    ld_vld = 1'b0; inc = 1'b0;
    @(negedge clk);
    check_eq("load_beats_inc", target1, 9);
    tick();

    repeat (20) tick();
    @(negedge clk);
    check_eq("midramp_busy", busy1, 1);
    tick();
    apply_reset();
    do_load(5'd3);
    tick();
    wait_idle(200);
    check_eq("post_reset_duty", duty1, 3);

    @(negedge clk);
    #1;
    check_eq("sb_q1_drained", q1.size(), 0);
    check_eq("sb_q3_drained", q3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
